// File: rtl/mage_pkg.sv
// rtl/mage_pkg.sv - Mage shared constants and data-memory arbiter types
package mage_pkg;

  localparam int N_BANKS    = 4;
  localparam int BANK_SIZE  = 256;
  localparam int N_DMEM_REQ = 4;

  typedef logic [$clog2(N_BANKS)-1:0]    dmem_bank_idx_t;
  typedef logic [$clog2(N_DMEM_REQ)-1:0] dmem_req_idx_t;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - Single-bank round-robin arbiter with grant-driven pointer
module dmem_rr_arbiter
  import mage_pkg::*;
#(
  parameter int N_REQ = N_DMEM_REQ
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
  output logic                     gnt_valid_o
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] prio_q;

  // Search from prio_q upward, wrapping, and grant the first active requester
  always_comb begin
    int c;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    c           = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = (int'(prio_q) + i) % N_REQ;
      if (!gnt_valid_o && req_i[c]) begin
        gnt_valid_o = 1'b1;
        gnt_o[c]    = 1'b1;
        gnt_idx_o   = IW'(c);
      end
    end
  end

  // Pointer moves past the winner only when a grant happens
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prio_q <= '0;
    end else if (gnt_valid_o) begin
      prio_q <= IW'((int'(gnt_idx_o) + 1) % N_REQ);
    end
  end

endmodule

// File: rtl/dmem_bank_arbiter.sv
// rtl/dmem_bank_arbiter.sv - Word-interleaved multi-bank data memory arbiter
module dmem_bank_arbiter #(
  parameter int N_REQ     = mage_pkg::N_DMEM_REQ,
  parameter int N_BANKS   = mage_pkg::N_BANKS,
  parameter int BANK_SIZE = mage_pkg::BANK_SIZE,
  parameter int AW        = $clog2(N_BANKS * BANK_SIZE)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [N_REQ-1:0]                       req_i,
  input  logic [N_REQ-1:0]                       we_i,
  input  logic [N_REQ-1:0][AW-1:0]               addr_i,
  input  logic [N_REQ-1:0][31:0]                 wdata_i,
  output logic [N_REQ-1:0]                       gnt_o,
  output logic [N_REQ-1:0]                       rvalid_o,
  output logic [N_REQ-1:0][31:0]                 rdata_o,
  output logic [N_BANKS-1:0]                     dmem_req_o,
  output logic [N_BANKS-1:0]                     dmem_we_o,
  output logic [N_BANKS-1:0][$clog2(BANK_SIZE)-1:0] dmem_addr_o,
  output logic [N_BANKS-1:0][31:0]               dmem_wdata_o,
  input  logic [N_BANKS-1:0][31:0]               dmem_rdata_i
);

  localparam int BW = $clog2(N_BANKS);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]                 req_eff;
  logic [N_BANKS-1:0][N_REQ-1:0]    bank_req;
  logic [N_BANKS-1:0][N_REQ-1:0]    bank_gnt;
  logic [N_BANKS-1:0][IW-1:0]       win_idx;
  logic [N_BANKS-1:0]               win_vld;
  logic [N_BANKS-1:0]               rd_pend_q;
  logic [N_BANKS-1:0][IW-1:0]       rd_id_q;

  // Requests are masked while in reset so no grant or bank access can leak out
  assign req_eff = req_i & {N_REQ{rst_n_i}};

  // Route each requester to the bank selected by its low address bits
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int r = 0; r < N_REQ; r++) begin
        bank_req[b][r] = req_eff[r] && (addr_i[r][BW-1:0] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    dmem_rr_arbiter #(
      .N_REQ(N_REQ)
    ) u_arb (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .req_i      (bank_req[b]),
      .gnt_o      (bank_gnt[b]),
      .gnt_idx_o  (win_idx[b]),
      .gnt_valid_o(win_vld[b])
    );
  end

  // Merge per-bank grants and drive each bank from its winner, zero when idle
  always_comb begin
    gnt_o        = '0;
    dmem_req_o   = '0;
    dmem_we_o    = '0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
      if (win_vld[b]) begin
        dmem_req_o[b]   = 1'b1;
        dmem_we_o[b]    = we_i[win_idx[b]];
        dmem_addr_o[b]  = addr_i[win_idx[b]][AW-1:BW];
        dmem_wdata_o[b] = wdata_i[win_idx[b]];
      end
    end
  end

  // Remember which requester owns the read data returning next cycle per bank
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_pend_q <= '0;
      rd_id_q   <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        rd_pend_q[b] <= win_vld[b] && !we_i[win_idx[b]];
        rd_id_q[b]   <= win_idx[b];
      end
    end
  end

  // Steer returning bank data to the owning requester; others see zero
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (rd_pend_q[b]) begin
        rvalid_o[rd_id_q[b]] = 1'b1;
        rdata_o[rd_id_q[b]]  = dmem_rdata_i[b];
      end
    end
  end

  // A waiting requester must hold its request and payload until granted
  for (genvar r = 0; r < N_REQ; r++) begin : g_chk
    a_hold_payload : assert property (
      @(posedge clk_i) disable iff (!rst_n_i)
      (req_i[r] && !gnt_o[r]) |=> (req_i[r] && we_i[r] == $past(we_i[r]) &&
                                   addr_i[r] == $past(addr_i[r]) &&
                                   wdata_i[r] == $past(wdata_i[r]))
    );
  end

endmodule

// File: doc/dmem_bank_arbiter.md
Name: dmem_bank_arbiter

Overview:
- Shares the multi-bank Mage data memory between N_REQ word-addressed requesters, such as PEA load/store streams and the host/DMA port.
- Addresses are word-interleaved across banks; each bank has an independent round-robin arbiter, so requesters hitting different banks proceed in parallel.
- Sits between the requesters and data_memory, drives its per-bank req/we/addr/wdata, and routes bank read data back to the winner one cycle later.

Parameters:
- N_REQ, 4, number of requester ports (>=2).
- N_BANKS, mage_pkg::N_BANKS, number of banks; power of two.
- BANK_SIZE, mage_pkg::BANK_SIZE, words per bank; power of two.
- AW, $clog2(N_BANKS*BANK_SIZE), requester word-address width.

Ports:
- clk_i in 1 clock
- rst_n_i in 1 asynchronous active-low reset
- req_i in [N_REQ] request valid per requester
- we_i in [N_REQ] 1=write, 0=read
- addr_i in [N_REQ][AW] word address
- wdata_i in [N_REQ][32] write data
- gnt_o out [N_REQ] request accepted this cycle
- rvalid_o out [N_REQ] read data valid
- rdata_o out [N_REQ][32] read data
- dmem_req_o out [N_BANKS] bank request
- dmem_we_o out [N_BANKS] bank write enable
- dmem_addr_o out [N_BANKS][$clog2(BANK_SIZE)] bank-local address
- dmem_wdata_o out [N_BANKS][32] bank write data
- dmem_rdata_i in [N_BANKS][32] bank read data (1-cycle SRAM latency)

Behaviour:
- Bank select = addr_i[$clog2(N_BANKS)-1:0]; bank-local address = addr_i[AW-1:$clog2(N_BANKS)].
- Per bank: combinational round-robin among requesters with req_i high targeting that bank.
  - Search starts at prio_q[bank] and wraps N_REQ-1 -> 0.
  - The winner gets gnt_o high in the same cycle; dmem_* for that bank is driven from the winner.
  - A requester targets exactly one bank, so it never receives two grants.
- prio_q[bank] updates only on a grant: prio_q <= (winner+1) mod N_REQ. No grant leaves it unchanged. Reset value 0.
- Unserved requester keeps req_i and its payload stable until gnt_o; payload changes while ungranted are a protocol error (assertion).
- Bank with no contender: dmem_req_o=0, we/addr/wdata driven 0.
- Read response pipeline:
  - Per bank registers rd_pend_q and rd_id_q capture "granted read" and the winner index.
  - In the next cycle, rvalid_o[rd_id_q]=1 and rdata_o[rd_id_q]=dmem_rdata_i[bank].
  - Fixed read latency: gnt -> rvalid exactly 1 cycle.
- Writes: gnt_o is the completion; no rvalid.
- Back-to-back: a requester may be granted every cycle. rvalid for cycle-t grants coincides with new grants at t+1.
- A requester has at most one rvalid per cycle, since it holds at most one grant per cycle.
- rdata_o for non-valid requesters is 0.
- Reset (async, any time): prio_q=0 and rd_pend_q=0. All outputs are 0 while rst_n_i low, since gnt and dmem_req are gated by reset state. In-flight reads are dropped with no rvalid after reset release.
- Fairness: with K requesters continuously contending one bank, each is granted at least once every K cycles.
- Sequential state: prio_q (N_BANKS x $clog2(N_REQ)), rd_pend_q (N_BANKS), rd_id_q (N_BANKS x $clog2(N_REQ)).

Decomposition:
- mage_pkg gains:
  - N_DMEM_REQ, the default N_REQ.
  - typedef dmem_bank_idx_t = logic [$clog2(N_BANKS)-1:0].
  - typedef dmem_req_idx_t = logic [$clog2(N_DMEM_REQ)-1:0].
- One sub-module, dmem_rr_arbiter: N_REQ-wide request vector in, one-hot grant plus index out, internal prio register with grant-driven update. Instantiate it N_BANKS times.
- Top level: bank decode, muxing, response registers.

Test Plan (N_REQ=4, N_BANKS=4, BANK_SIZE=256):
- Reset/idle: rst_n_i low then released with no req. All outputs stay 0; a req asserted mid-reset gets no gnt until release.
- Parallel banks: req0 reads addr 0x004 (bank 0, local 1), req1 reads 0x005 (bank 1, local 1), same cycle. Both gnt at t. dmem_addr_o[0]=dmem_addr_o[1]=1. rvalid0/rvalid1 at t+1 with the matching bank data.
- Conflict RR: all 4 hold reads to bank 2 continuously from reset. Grants are req0, req1, req2, req3, req0 on consecutive cycles; each rvalid follows 1 cycle later at the correct port.
- Pointer hold: req2 alone granted (prio=3), then req1 and req3 contend the same bank. req3 wins first, then req1.
- Write-then-read: req0 writes 0xDEADBEEF to 0x010, next cycle req3 reads 0x010. req3 rvalid with rdata 0xDEADBEEF; no rvalid for req0.
- Reset mid-read: a read is granted at t and rst_n_i asserts at t+0.5. No rvalid at t+1, and after release prio_q restarts at 0 (req0 wins a 0/1 conflict).
